// File: rtl/mem_wb_queue_if.sv
// MEM->WB queue bus: enqueue side from MEM, dequeue side to WB, plus occupancy.
// The slave modport is the queue; the master modport is the surrounding pipeline.
interface mem_wb_queue_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CTRL_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] br_add_out;
    logic [DATA_W-1:0] shift_out;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  dest_in;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result_out;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] pc_out;
    logic [REG_W-1:0]  dest_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, opcode, ctrl_in, alu_out, br_add_out, shift_out,
               pc_in, mem_rdata, dest_in, out_ready,
        output in_ready, out_valid, result_out, mem_data_out, pc_out,
               dest_out, ctrl_out, count
    );

    modport master (
        output in_valid, opcode, ctrl_in, alu_out, br_add_out, shift_out,
               pc_in, mem_rdata, dest_in, out_ready,
        input  in_ready, out_valid, result_out, mem_data_out, pc_out,
               dest_out, ctrl_out, count
    );
endinterface

// File: rtl/mem_wb_queue.sv
// DEPTH-entry MEM/WB FIFO for the lc3b pipeline; entries are transformed at enqueue.
// Define MEMWB_LDB_SEXT_EN to sign-extend the LDB byte instead of zero-extending it.
module mem_wb_queue #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CTRL_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    mem_wb_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [DATA_W-1:0] result_mem [DEPTH];
    logic [DATA_W-1:0] data_mem   [DEPTH];
    logic [DATA_W-1:0] pc_mem     [DEPTH];
    logic [REG_W-1:0]  dest_mem   [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;
    logic not_empty;
    logic not_full;

    logic [DATA_W-1:0] new_result;
    logic [DATA_W-1:0] new_mem_data;
    logic [REG_W-1:0]  new_dest;
    logic [CTRL_W-1:0] new_ctrl;
    logic [7:0]        ldb_byte;
    logic              ldb_fill;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends only on registered occupancy, never on out_ready.
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q < CNT_W'(DEPTH));
    assign push      = bus.in_valid && not_full;
    assign pop       = not_empty && bus.out_ready;

    always_comb begin
        new_result   = bus.alu_out;
        new_mem_data = bus.mem_rdata;
        new_dest     = bus.dest_in;
        new_ctrl     = bus.ctrl_in;
        ldb_byte     = bus.alu_out[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
`ifdef MEMWB_LDB_SEXT_EN
        ldb_fill     = ldb_byte[7];
`else
        ldb_fill     = 1'b0;
`endif
        case (bus.opcode)
            OP_LEA:  new_result = bus.br_add_out;
            OP_SHF:  new_result = bus.shift_out;
            default: new_result = bus.alu_out;
        endcase
        if (bus.opcode == OP_LDB)
            new_mem_data = {{(DATA_W - 8){ldb_fill}}, ldb_byte};
        // JSR/JSRR and TRAP always link into R7.
        if (bus.opcode == OP_JSR || bus.opcode == OP_TRAP)
            new_dest = '1;
        if (bus.opcode == OP_LDI || bus.opcode == OP_STI)
            new_ctrl = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                result_mem[i] <= '0;
                data_mem[i]   <= '0;
                pc_mem[i]     <= '0;
                dest_mem[i]   <= '0;
                ctrl_mem[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                result_mem[wr_ptr] <= new_result;
                data_mem[wr_ptr]   <= new_mem_data;
                pc_mem[wr_ptr]     <= bus.pc_in;
                dest_mem[wr_ptr]   <= new_dest;
                ctrl_mem[wr_ptr]   <= new_ctrl;
                wr_ptr             <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head fields are masked so an empty queue never exposes stale storage.
    assign bus.in_ready     = not_full;
    assign bus.out_valid    = not_empty;
    assign bus.count        = count_q;
    assign bus.result_out   = not_empty ? result_mem[rd_ptr] : '0;
    assign bus.mem_data_out = not_empty ? data_mem[rd_ptr]   : '0;
    assign bus.pc_out       = not_empty ? pc_mem[rd_ptr]     : '0;
    assign bus.dest_out     = not_empty ? dest_mem[rd_ptr]   : '0;
    assign bus.ctrl_out     = not_empty ? ctrl_mem[rd_ptr]   : '0;
endmodule

// File: tb/tb_mem_wb_queue.sv
// Directed bench for mem_wb_queue: a transform vector table plus hand-written
// sequences for ordering, full back-pressure, flush and asynchronous reset.
module tb_mem_wb_queue;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

`ifdef MEMWB_LDB_SEXT_EN
    localparam logic [15:0] LDB_HI = 16'hFFA5;
    localparam logic [15:0] LDB_LO = 16'hFFC3;
`else
    localparam logic [15:0] LDB_HI = 16'h00A5;
    localparam logic [15:0] LDB_LO = 16'h00C3;
`endif

    typedef struct {
        logic [3:0]  opcode;
        logic [15:0] alu;
        logic [15:0] br;
        logic [15:0] shift;
        logic [15:0] pc;
        logic [15:0] mem;
        logic [2:0]  dest;
        logic [31:0] ctrl;
        logic [15:0] exp_result;
        logic [15:0] exp_mem;
        logic [15:0] exp_pc;
        logic [2:0]  exp_dest;
        logic [31:0] exp_ctrl;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_compared;
    int   n_failed;
    vec_t vectors [12];
    vec_t tmp;

    mem_wb_queue_if #(.DATA_W(16), .REG_W(3), .CTRL_W(32), .DEPTH(2)) bus ();

    mem_wb_queue #(.DATA_W(16), .REG_W(3), .CTRL_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        bus.opcode     = v.opcode;
        bus.alu_out    = v.alu;
        bus.br_add_out = v.br;
        bus.shift_out  = v.shift;
        bus.pc_in      = v.pc;
        bus.mem_rdata  = v.mem;
        bus.dest_in    = v.dest;
        bus.ctrl_in    = v.ctrl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkHead(input string tag, input vec_t v);
        checkOutput({tag, "_valid"},  32'(bus.out_valid),    32'd1);
        checkOutput({tag, "_result"}, 32'(bus.result_out),   32'(v.exp_result));
        checkOutput({tag, "_mem"},    32'(bus.mem_data_out), 32'(v.exp_mem));
        checkOutput({tag, "_pc"},     32'(bus.pc_out),       32'(v.exp_pc));
        checkOutput({tag, "_dest"},   32'(bus.dest_out),     32'(v.exp_dest));
        checkOutput({tag, "_ctrl"},   32'(bus.ctrl_out),     v.exp_ctrl);
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_count"},  32'(bus.count),        32'd0);
        checkOutput({tag, "_valid"},  32'(bus.out_valid),    32'd0);
        checkOutput({tag, "_ready"},  32'(bus.in_ready),     32'd1);
        checkOutput({tag, "_result"}, 32'(bus.result_out),   32'd0);
        checkOutput({tag, "_mem"},    32'(bus.mem_data_out), 32'd0);
        checkOutput({tag, "_pc"},     32'(bus.pc_out),       32'd0);
        checkOutput({tag, "_dest"},   32'(bus.dest_out),     32'd0);
        checkOutput({tag, "_ctrl"},   32'(bus.ctrl_out),     32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        //             op       alu       br        shift     pc        mem       d     ctrl            result    mem       pc        d     ctrl
        vectors[0]  = '{OP_ADD,  16'h1234, 16'h0000, 16'h0000, 16'h0100, 16'hBEEF, 3'd2, 32'h00000011,  16'h1234, 16'hBEEF, 16'h0100, 3'd2, 32'h00000011};
        vectors[1]  = '{OP_LDB,  16'h0005, 16'h0000, 16'h0000, 16'h0200, 16'hA5C3, 3'd4, 32'h00000022,  16'h0005, LDB_HI,   16'h0200, 3'd4, 32'h00000022};
        vectors[2]  = '{OP_LDB,  16'h0004, 16'h0000, 16'h0000, 16'h0202, 16'hA5C3, 3'd1, 32'h00000033,  16'h0004, LDB_LO,   16'h0202, 3'd1, 32'h00000033};
        vectors[3]  = '{OP_LDB,  16'h0006, 16'h0000, 16'h0000, 16'h0204, 16'h7F12, 3'd6, 32'h00000034,  16'h0006, 16'h0012, 16'h0204, 3'd6, 32'h00000034};
        vectors[4]  = '{OP_JSR,  16'h00AA, 16'h0000, 16'h0000, 16'h3002, 16'h0000, 3'd3, 32'h00000044,  16'h00AA, 16'h0000, 16'h3002, 3'd7, 32'h00000044};
        vectors[5]  = '{OP_TRAP, 16'h0025, 16'h0000, 16'h0000, 16'h1236, 16'h5555, 3'd1, 32'h00000055,  16'h0025, 16'h5555, 16'h1236, 3'd7, 32'h00000055};
        vectors[6]  = '{OP_LEA,  16'h1111, 16'h4000, 16'h2222, 16'h0300, 16'h0000, 3'd5, 32'h00000066,  16'h4000, 16'h0000, 16'h0300, 3'd5, 32'h00000066};
        vectors[7]  = '{OP_SHF,  16'h1111, 16'h4000, 16'h8001, 16'h0302, 16'h0000, 3'd0, 32'h00000077,  16'h8001, 16'h0000, 16'h0302, 3'd0, 32'h00000077};
        vectors[8]  = '{OP_LDI,  16'h0010, 16'h0000, 16'h0000, 16'h0400, 16'hCAFE, 3'd3, 32'hDEADBEEF,  16'h0010, 16'hCAFE, 16'h0400, 3'd3, 32'h00000000};
        vectors[9]  = '{OP_STI,  16'h0020, 16'h0000, 16'h0000, 16'h0402, 16'h0F0F, 3'd2, 32'h12345678,  16'h0020, 16'h0F0F, 16'h0402, 3'd2, 32'h00000000};
        vectors[10] = '{OP_LDR,  16'h0003, 16'h0000, 16'h0000, 16'h0404, 16'hA5C3, 3'd6, 32'h00000088,  16'h0003, 16'hA5C3, 16'h0404, 3'd6, 32'h00000088};
        vectors[11] = '{OP_JMP,  16'h0000, 16'h0000, 16'h0000, 16'h0406, 16'h0000, 3'd5, 32'hFFFFFFFF,  16'h0000, 16'h0000, 16'h0406, 3'd5, 32'hFFFFFFFF};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(vectors[0]);
        #12;
        checkEmpty("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Each vector: push into an empty queue, inspect the head, then drain it.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vectors[i]);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            checkHead($sformatf("vec%0d", i), vectors[i]);
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'd1);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checkOutput($sformatf("vec%0d_drain_count", i), 32'(bus.count), 32'd0);
            checkOutput($sformatf("vec%0d_drain_valid", i), 32'(bus.out_valid), 32'd0);
        end

        // Back-to-back JSR then LEA: FIFO order and per-entry transforms.
        @(negedge clk);
        applyStimulus(vectors[4]);
        bus.in_valid = 1'b1;
        tick();
        applyStimulus(vectors[6]);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("order_count", 32'(bus.count), 32'd2);
        checkHead("order_first", vectors[4]);
        bus.out_ready = 1'b1;
        tick();
        checkHead("order_second", vectors[6]);
        tick();
        bus.out_ready = 1'b0;
        checkOutput("order_drained", 32'(bus.count), 32'd0);

        // Fill, then a blocked push, then push while popping from full and from one.
        @(negedge clk);
        applyStimulus(vectors[0]);
        bus.in_valid = 1'b1;
        tick();
        applyStimulus(vectors[5]);
        tick();
        checkOutput("full_count", 32'(bus.count), 32'd2);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(vectors[7]);
        tick();
        checkOutput("full_blocked_count", 32'(bus.count), 32'd2);
        checkHead("full_blocked_head", vectors[0]);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("full_pop_count", 32'(bus.count), 32'd1);
        checkHead("full_pop_head", vectors[5]);
        tick();
        checkOutput("pushpop_count", 32'(bus.count), 32'd1);
        checkHead("pushpop_head", vectors[7]);
        bus.in_valid  = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("pushpop_drained", 32'(bus.count), 32'd0);

        // Flush with a concurrent push: everything discarded.
        @(negedge clk);
        applyStimulus(vectors[1]);
        bus.in_valid = 1'b1;
        tick();
        applyStimulus(vectors[2]);
        tick();
        checkOutput("preflush_count", 32'(bus.count), 32'd2);
        applyStimulus(vectors[3]);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checkEmpty("flush");

        // LDI bubble, then reset dropped between clock edges.
        @(negedge clk);
        applyStimulus(vectors[8]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checkHead("ldi_bubble", vectors[8]);
        #2;
        rst_n = 1'b0;
        #1;
        checkEmpty("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkEmpty("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
